alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: accept, execute, respond.
// Optional macro ALU_ARB_RR_EN selects round-robin grant; otherwise requester 0 has priority.
module alu_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_ovf,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_control,
  output logic               alu_enable,
  input  logic [WIDTH-1:0]   alu_dOut,
  input  logic               alu_overflow
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant;
  logic             accept;
  logic             sel;
  logic             owner_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_ovf_q;

`ifdef ALU_ARB_RR_EN
  logic rr_ptr_q;

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant = req_valid;
    if (&req_valid) grant = rr_ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr_q <= 1'b0;
    else if (accept) rr_ptr_q <= ~sel;
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`endif

  assign accept = |req_ready;
  assign sel    = req_ready[1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; ready is gated by reset so nothing looks acceptable while held in reset.
  always_comb begin
    req_ready  = (state_q == StIdle && rst_n) ? grant : 2'b00;
    alu_enable = (state_q == StExec);
    busy       = (state_q != StIdle);
    rsp_valid  = (state_q == StDone) ? {owner_q, ~owner_q} : 2'b00;
  end

  // Payload is sampled only on the acceptance edge; result only at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= sel;
        op_q    <= sel ? req_op[3:2] : req_op[1:0];
        a_q     <= sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        b_q     <= sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      end
      if (state_q == StExec) begin
        rsp_data_q <= alu_dOut;
        rsp_ovf_q  <= alu_overflow;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_ovf     = rsp_ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU on the shared ALU port.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready;
  logic [3:0]       req_op;
  logic [15:0]      req_a, req_b;
  logic [1:0]       rsp_valid;
  logic [7:0]       rsp_data;
  logic             rsp_ovf, busy;
  logic [7:0]       alu_a, alu_b;
  logic [1:0]       alu_control;
  logic             alu_enable;
  logic [7:0]       alu_dout;
  logic             alu_ovf;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ovf      (rsp_ovf),
    .busy         (busy),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_enable   (alu_enable),
    .alu_dOut     (alu_dout),
    .alu_overflow (alu_ovf)
  );

  always #5 clk = ~clk;

  // Shared ALU: signed overflow on add/sub, none on logic ops.
  always_comb begin
    alu_dout = 8'h00;
    alu_ovf  = 1'b0;
    case (alu_control)
      2'b00: begin
        alu_dout = alu_a + alu_b;
        alu_ovf  = (alu_a[7] == alu_b[7]) && (alu_dout[7] != alu_a[7]);
      end
      2'b01: begin
        alu_dout = alu_a - alu_b;
        alu_ovf  = (alu_a[7] != alu_b[7]) && (alu_dout[7] != alu_a[7]);
      end
      2'b10:   alu_dout = alu_a & alu_b;
      default: alu_dout = alu_a | alu_b;
    endcase
  end

  typedef struct {
    int         req;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one request and follow it through EXEC, DONE and back to IDLE.
  task automatic do_op(input vec_t v);
    logic [1:0] exp_rdy;
    exp_rdy = (v.req == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    req_op = {2{~v.op}};
    req_a  = 16'hEEEE;
    req_b  = 16'h1111;
    req_op[v.req*2 +: 2] = v.op;
    req_a[v.req*8 +: 8]  = v.a;
    req_b[v.req*8 +: 8]  = v.b;
    req_valid = exp_rdy;
    #1;
    chk("idle_ready", req_ready, exp_rdy);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("exec_enable", alu_enable, 1);
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    chk("exec_alu_a", alu_a, v.a);
    chk("exec_alu_b", alu_b, v.b);
    chk("exec_alu_ctl", alu_control, v.op);
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, exp_rdy);
    chk("done_rsp_data", rsp_data, v.data);
    chk("done_rsp_ovf", rsp_ovf, v.ovf);
    chk("done_enable", alu_enable, 0);
    chk("done_ready", req_ready, 0);
    @(negedge clk);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("hold_rsp_data", rsp_data, v.data);
    chk("hold_rsp_ovf", rsp_ovf, v.ovf);
    chk("idle_busy", busy, 0);
    chk("hold_alu_a", alu_a, v.a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         n_acc;
    int         acc_cyc[4];
    logic [1:0] acc_who[4];
    logic       saw_rsp;

    vecs[0] = '{0, 2'b00, 8'd100, 8'd27,  8'd127, 1'b0};
    vecs[1] = '{1, 2'b01, 8'h80,  8'h01,  8'h7F,  1'b1};
    vecs[2] = '{0, 2'b10, 8'h0F,  8'h3C,  8'h0C,  1'b0};
    vecs[3] = '{0, 2'b11, 8'h0F,  8'h3C,  8'h3F,  1'b0};
    vecs[4] = '{0, 2'b00, 8'd127, 8'd1,   8'h80,  1'b1};
    vecs[5] = '{1, 2'b10, 8'hFF,  8'hA5,  8'hA5,  1'b0};
    vecs[6] = '{1, 2'b00, 8'hFF,  8'h01,  8'h00,  1'b0};
    vecs[7] = '{0, 2'b01, 8'h00,  8'h01,  8'hFF,  1'b0};

    // Reset with both requesters pushing: nothing may look ready.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op    = 4'b0101;
    req_a     = 16'h1234;
    req_b     = 16'h5678;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", alu_enable, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctl", alu_control, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Both requesters valid continuously from a fresh reset.
    pulse_reset();
    req_op    = 4'b0000;
    req_a     = {8'd3, 8'd1};
    req_b     = {8'd4, 8'd2};
    req_valid = 2'b11;
    n_acc     = 0;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (req_ready != 2'b00 && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        acc_who[n_acc] = req_ready;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("arb_count", n_acc, 3);
    if (n_acc == 3) begin
      for (int k = 0; k < 3; k++) chk("arb_spacing", acc_cyc[k], 3 * k);
      chk("arb_first", acc_who[0], 2'b01);
`ifdef ALU_ARB_RR_EN
      chk("arb_second_rr", acc_who[1], 2'b10);
`else
      chk("arb_second_fixed", acc_who[1], 2'b01);
`endif
      chk("arb_third", acc_who[2], 2'b01);
    end

    // Reset in EXEC discards the transaction.
    @(negedge clk);
    req_op    = 4'b0000;
    req_a     = {8'h00, 8'd50};
    req_b     = {8'h00, 8'd60};
    req_valid = 2'b01;
    @(negedge clk);
    chk("rstexec_enable", alu_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("rstexec_busy", busy, 0);
    chk("rstexec_en_off", alu_enable, 0);
    chk("rstexec_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstexec_rel_busy", busy, 0);
    chk("rstexec_rel_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    saw_rsp   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) saw_rsp = 1'b1;
    end
    chk("rstexec_no_rsp", saw_rsp, 0);
    chk("rstexec_rsp_data", rsp_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
